// File: rtl/baccarat_dealer_fsm.sv
// Baccarat dealer control FSM: sequences card loads, applies third-card rules, drives win lights.
// Optional AUTO_REDEAL_EN: after HOLD_CYCLES cycles in DONE a new round starts at P1.
module baccarat_dealer_fsm #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_done
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BCHK = 4'd7,
    S_D3   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   redeal;

  // Dealer third-card table; face cards and tens count as zero.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] pc3);
    logic [3:0] v;
    logic       draw;
    v = (pc3 >= 4'd10) ? 4'd0 : pc3;
    if (ds <= 4'd2)
      draw = 1'b1;
    else if (ds == 4'd3)
      draw = (v != 4'd8);
    else if (ds == 4'd4)
      draw = (v >= 4'd2) && (v <= 4'd7);
    else if (ds == 4'd5)
      draw = (v >= 4'd4) && (v <= 4'd7);
    else if (ds == 4'd6)
      draw = (v >= 4'd6) && (v <= 4'd7);
    else
      draw = 1'b0;
    return draw;
  endfunction

`ifdef AUTO_REDEAL_EN
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb)
      hold_cnt <= '0;
    else if ((state_nxt == S_DONE) && (state != S_DONE))
      hold_cnt <= CNT_W'(HOLD_CYCLES);
    else if ((state == S_DONE) && (hold_cnt != '0))
      hold_cnt <= hold_cnt - CNT_W'(1);
  end

  // The counter reads 1 during the last DONE cycle.
  assign redeal = (state == S_DONE) && (hold_cnt <= CNT_W'(1));
`else
  assign redeal = 1'b0;
`endif

  always_ff @(posedge slow_clock or posedge resetb) begin
    if (resetb)
      state <= S_RST;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_RST;
    case (state)
      S_RST:  state_nxt = S_P1;
      S_P1:   state_nxt = S_D1;
      S_D1:   state_nxt = S_P2;
      S_P2:   state_nxt = S_D2;
      S_D2:   state_nxt = S_EVAL;
      S_EVAL: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8))
          state_nxt = S_DONE;
        else if (pscore <= 4'd5)
          state_nxt = S_P3;
        else if (dscore <= 4'd5)
          state_nxt = S_D3;
        else
          state_nxt = S_DONE;
      end
      S_P3:   state_nxt = S_BCHK;
      S_BCHK: state_nxt = dealer_draws(dscore, pcard3) ? S_D3 : S_DONE;
      S_D3:   state_nxt = S_DONE;
      S_DONE: state_nxt = redeal ? S_P1 : S_DONE;
      default: state_nxt = S_RST;
    endcase
  end

  always_comb begin
    load_pcard1      = (state == S_P1);
    load_dcard1      = (state == S_D1);
    load_pcard2      = (state == S_P2);
    load_dcard2      = (state == S_D2);
    load_pcard3      = (state == S_P3);
    load_dcard3      = (state == S_D3);
    game_done        = (state == S_DONE);
    player_win_light = (state == S_DONE) && (pscore >= dscore);
    dealer_win_light = (state == S_DONE) && (dscore >= pscore);
  end

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Directed bench for baccarat_dealer_fsm: card sequencing, third-card rules, lights, reset.
module tb_baccarat_dealer_fsm;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, game_done;

  int errors = 0;
  int checks = 0;

  baccarat_dealer_fsm #(.HOLD_CYCLES(8)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .game_done        (game_done)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // Observed vector: {p1, d1, p2, d2, p3, d3, game_done, player_light, dealer_light}
  task automatic chk(input logic [5:0] ld, input logic d, input logic pl, input logic dl,
                     input string tag);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3, load_dcard3,
           game_done, player_win_light, dealer_win_light};
    exp = {ld, d, pl, dl};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    @(negedge slow_clock);
  endtask

  // Reset, release, and walk the four initial loads plus EVAL (edges 1..5).
  task automatic deal4(input string tag);
    resetb = 1'b1;
    @(negedge slow_clock);
    @(negedge slow_clock);
    chk(6'b000000, 1'b0, 1'b0, 1'b0, {tag, "_rst"});
    resetb = 1'b0;
    tick(); chk(6'b100000, 1'b0, 1'b0, 1'b0, {tag, "_p1"});
    tick(); chk(6'b010000, 1'b0, 1'b0, 1'b0, {tag, "_d1"});
    tick(); chk(6'b001000, 1'b0, 1'b0, 1'b0, {tag, "_p2"});
    tick(); chk(6'b000100, 1'b0, 1'b0, 1'b0, {tag, "_d2"});
    tick(); chk(6'b000000, 1'b0, 1'b0, 1'b0, {tag, "_eval"});
  endtask

  initial begin
    resetb = 1'b1;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;

    // Natural 8 vs 3: DONE on edge 6, player light only.
    pscore = 4'd8; dscore = 4'd3; pcard3 = 4'd0;
    deal4("nat");
    tick(); chk(6'b000000, 1'b1, 1'b1, 1'b0, "nat_done_e6");
    tick(); chk(6'b000000, 1'b1, 1'b1, 1'b0, "nat_done_hold");

    // Both draw: 4 vs 3, pcard3=Q (value 0); final 5 vs 9.
    pscore = 4'd4; dscore = 4'd3; pcard3 = 4'd12;
    deal4("both");
    tick(); chk(6'b000010, 1'b0, 1'b0, 1'b0, "both_p3_e6");
    tick(); chk(6'b000000, 1'b0, 1'b0, 1'b0, "both_bchk_e7");
    tick(); chk(6'b000001, 1'b0, 1'b0, 1'b0, "both_d3_e8");
    pscore = 4'd5; dscore = 4'd9;
    tick(); chk(6'b000000, 1'b1, 1'b0, 1'b1, "both_done_e9");

    // Dealer on 3 stands against an 8 third card.
    pscore = 4'd2; dscore = 4'd3; pcard3 = 4'd8;
    deal4("d3s8");
    tick(); chk(6'b000010, 1'b0, 1'b0, 1'b0, "d3s8_p3_e6");
    tick(); chk(6'b000000, 1'b0, 1'b0, 1'b0, "d3s8_bchk_e7");
    tick(); chk(6'b000000, 1'b1, 1'b0, 1'b1, "d3s8_done_e8");

    // Dealer on 6 draws against a 7 third card.
    pscore = 4'd3; dscore = 4'd6; pcard3 = 4'd7;
    deal4("d6d7");
    tick(); chk(6'b000010, 1'b0, 1'b0, 1'b0, "d6d7_p3_e6");
    tick(); chk(6'b000000, 1'b0, 1'b0, 1'b0, "d6d7_bchk_e7");
    tick(); chk(6'b000001, 1'b0, 1'b0, 1'b0, "d6d7_d3_e8");
    tick(); chk(6'b000000, 1'b1, 1'b0, 1'b1, "d6d7_done_e9");

    // Dealer on 4 stands against an ace.
    pscore = 4'd5; dscore = 4'd4; pcard3 = 4'd1;
    deal4("d4a");
    tick(); chk(6'b000010, 1'b0, 1'b0, 1'b0, "d4a_p3_e6");
    tick(); chk(6'b000000, 1'b0, 1'b0, 1'b0, "d4a_bchk_e7");
    tick(); chk(6'b000000, 1'b1, 1'b1, 1'b0, "d4a_done_e8");

    // Player stands on 7, dealer draws on 5.
    pscore = 4'd7; dscore = 4'd5; pcard3 = 4'd0;
    deal4("pstd");
    tick(); chk(6'b000001, 1'b0, 1'b0, 1'b0, "pstd_d3_e6");
    tick(); chk(6'b000000, 1'b1, 1'b1, 1'b0, "pstd_done_e7");

    // Out-of-contract scores still terminate; compared unsigned.
    pscore = 4'd12; dscore = 4'd15; pcard3 = 4'd0;
    deal4("oor");
    tick(); chk(6'b000000, 1'b1, 1'b0, 1'b1, "oor_done_e6");

    // Reset asserted in D1 drops the load without a clock edge.
    pscore = 4'd1; dscore = 4'd1; pcard3 = 4'd0;
    resetb = 1'b1;
    @(negedge slow_clock);
    resetb = 1'b0;
    tick(); chk(6'b100000, 1'b0, 1'b0, 1'b0, "mid_p1");
    tick(); chk(6'b010000, 1'b0, 1'b0, 1'b0, "mid_d1");
    #2 resetb = 1'b1;
    #1 chk(6'b000000, 1'b0, 1'b0, 1'b0, "mid_async_rst");
    @(negedge slow_clock);
    resetb = 1'b0;
    tick(); chk(6'b100000, 1'b0, 1'b0, 1'b0, "mid_restart_p1");

    // Tie 6/6, both stand; then DONE duration.
    pscore = 4'd6; dscore = 4'd6; pcard3 = 4'd0;
    deal4("tie");
    tick(); chk(6'b000000, 1'b1, 1'b1, 1'b1, "tie_done_e6");
    for (int i = 0; i < 7; i++) begin
      tick(); chk(6'b000000, 1'b1, 1'b1, 1'b1, "tie_done_hold");
    end
    tick();
`ifdef AUTO_REDEAL_EN
    chk(6'b100000, 1'b0, 1'b0, 1'b0, "tie_redeal_p1");
`else
    chk(6'b000000, 1'b1, 1'b1, 1'b1, "tie_done_terminal");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
